// File: rtl/rom2ram_copy_ctrl.sv
// Purpose : copies DEPTH words from a synchronous ROM into a single-port synchronous RAM
//           on a start pulse, then optionally re-reads both memories and counts mismatches.
// Latency : 1 + (1+VERIFY_EN)*(DEPTH+RD_LAT) cycles from accepted start to the done pulse.
// Backpressure: none; start is ignored while busy or in DONE, and abort cancels the job.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start, abort            job request (IDLE only) / job cancel (COPY or VERIFY)
//   busy, done              job in progress / one-cycle completion pulse
//   rom_addr, rom_data      ROM read port (data RD_LAT cycles after address)
//   ram_addr, ram_we,
//   ram_din, ram_dout       RAM port (write during COPY, read during VERIFY)
//   err_cnt, first_err_addr,
//   err_flag                verify results, held until the next accepted start
module rom2ram_copy_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int RD_LAT    = 1,
  parameter int VERIFY_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              err_flag
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COPY,
    S_VERIFY,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t                         state_q, state_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;       // read/issue counter
  logic                           issue_q, issue_d;     // counter currently issuing reads
  logic [RD_LAT-1:0]              dly_vld_q, dly_vld_d; // issue valid, delayed by RD_LAT
  logic [RD_LAT-1:0][ADDR_W-1:0]  dly_addr_q, dly_addr_d;
  logic [ADDR_W:0]                err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]              first_err_q, first_err_d;

  logic                           pipe_vld;
  logic [ADDR_W-1:0]              pipe_addr;
  logic                           phase_end;
  logic                           wr_en;

  // The oldest pipe stage lines up with the data currently returned by both memories.
  assign pipe_vld  = dly_vld_q[RD_LAT-1];
  assign pipe_addr = dly_addr_q[RD_LAT-1];
  // A phase ends when the data for the last address has come back.
  assign phase_end = pipe_vld && (pipe_addr == LAST_ADDR);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_d     = issue_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    wr_en       = 1'b0;

    // Delay pipe shifts every cycle; stage 0 captures the current issue.
    dly_vld_d[0]  = issue_q;
    dly_addr_d[0] = addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      dly_vld_d[i]  = dly_vld_q[i-1];
      dly_addr_d[i] = dly_addr_q[i-1];
    end

    // Issue counter stops at the last address instead of wrapping.
    if (issue_q) begin
      if (addr_q == LAST_ADDR) begin
        issue_d = 1'b0;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        // start has priority over abort here; abort is meaningless in IDLE.
        if (start) begin
          state_d     = S_COPY;
          addr_d      = '0;
          issue_d     = 1'b1;
          dly_vld_d   = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
        end
      end

      S_COPY: begin
        if (abort) begin
          state_d   = S_IDLE;
          issue_d   = 1'b0;
          dly_vld_d = '0;
        end else begin
          wr_en = pipe_vld;
          if (phase_end) begin
            if (VERIFY_EN != 0) begin
              state_d   = S_VERIFY;
              addr_d    = '0;
              issue_d   = 1'b1;
              dly_vld_d = '0;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end

      S_VERIFY: begin
        if (abort) begin
          state_d   = S_IDLE;
          issue_d   = 1'b0;
          dly_vld_d = '0;
        end else begin
          if (pipe_vld && (rom_data != ram_dout)) begin
            err_cnt_d = err_cnt_q + (ADDR_W+1)'(1);
            if (err_cnt_q == '0) begin
              first_err_d = pipe_addr;
            end
          end
          if (phase_end) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      issue_q     <= 1'b0;
      dly_vld_q   <= '0;
      dly_addr_q  <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_q     <= issue_d;
      dly_vld_q   <= dly_vld_d;
      dly_addr_q  <= dly_addr_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  assign busy           = (state_q == S_COPY) || (state_q == S_VERIFY);
  assign done           = (state_q == S_DONE);
  assign rom_addr       = addr_q;
  // COPY writes at the delayed address; VERIFY reads RAM alongside the ROM.
  assign ram_addr       = (state_q == S_COPY) ? pipe_addr : addr_q;
  assign ram_we         = wr_en;
  // ROM data goes straight to the RAM; zeroed when not writing so the bus idles at 0.
  assign ram_din        = wr_en ? rom_data : '0;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign err_flag       = (err_cnt_q != '0);

endmodule

// File: tb/tb_rom2ram_copy_ctrl.sv
module tb_rom2ram_copy_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_m    [3];
  logic       abort_m    [3];
  logic       busy_m     [3];
  logic       done_m     [3];
  logic       ram_we_m   [3];
  logic       err_flag_m [3];
  logic [9:0] rom_addr_m [3];
  logic [9:0] ram_addr_m [3];
  logic [9:0] first_err_m[3];
  logic [7:0] rom_data_m [3];
  logic [7:0] ram_din_m  [3];
  logic [7:0] ram_dout_m [3];
  logic [10:0] err_cnt_m [3];

  logic [7:0] rom_m     [3][1024];
  logic [7:0] corrupt_m [3][1024];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic int dep_of(input int w);
    case (w)
      0:       return 1024;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  function automatic int lat_of(input int w);
    case (w)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int ver_of(input int w);
    return (w == 1) ? 0 : 1;
  endfunction

  function automatic int job_len(input int w);
    return 1 + (1 + ver_of(w)) * (dep_of(w) + lat_of(w));
  endfunction

  rom2ram_copy_ctrl #(.DATA_W(8), .ADDR_W(10), .DEPTH(1024), .RD_LAT(1), .VERIFY_EN(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_m[0]), .abort(abort_m[0]), .busy(busy_m[0]),
    .done(done_m[0]), .rom_addr(rom_addr_m[0]), .rom_data(rom_data_m[0]), .ram_addr(ram_addr_m[0]),
    .ram_we(ram_we_m[0]), .ram_din(ram_din_m[0]), .ram_dout(ram_dout_m[0]), .err_cnt(err_cnt_m[0]),
    .first_err_addr(first_err_m[0]), .err_flag(err_flag_m[0]));

  rom2ram_copy_ctrl #(.DATA_W(8), .ADDR_W(10), .DEPTH(16), .RD_LAT(3), .VERIFY_EN(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_m[1]), .abort(abort_m[1]), .busy(busy_m[1]),
    .done(done_m[1]), .rom_addr(rom_addr_m[1]), .rom_data(rom_data_m[1]), .ram_addr(ram_addr_m[1]),
    .ram_we(ram_we_m[1]), .ram_din(ram_din_m[1]), .ram_dout(ram_dout_m[1]), .err_cnt(err_cnt_m[1]),
    .first_err_addr(first_err_m[1]), .err_flag(err_flag_m[1]));

  rom2ram_copy_ctrl #(.DATA_W(8), .ADDR_W(10), .DEPTH(1), .RD_LAT(2), .VERIFY_EN(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_m[2]), .abort(abort_m[2]), .busy(busy_m[2]),
    .done(done_m[2]), .rom_addr(rom_addr_m[2]), .rom_data(rom_data_m[2]), .ram_addr(ram_addr_m[2]),
    .ram_we(ram_we_m[2]), .ram_din(ram_din_m[2]), .ram_dout(ram_dout_m[2]), .err_cnt(err_cnt_m[2]),
    .first_err_addr(first_err_m[2]), .err_flag(err_flag_m[2]));

  // Synchronous memory models: data appears RD_LAT cycles after the address.
  // RAM read data is XORed with a corruption mask to emulate post-copy damage.
  for (genvar g = 0; g < 3; g++) begin : g_mem
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 2;
    logic [9:0] rp [L];
    logic [9:0] mp [L];
    logic [7:0] ram [1024];
    always @(posedge clk) begin
      rp[0] <= rom_addr_m[g];
      mp[0] <= ram_addr_m[g];
      for (int i = 1; i < L; i++) begin
        rp[i] <= rp[i-1];
        mp[i] <= mp[i-1];
      end
      if (ram_we_m[g]) ram[ram_addr_m[g]] <= ram_din_m[g];
    end
    assign rom_data_m[g] = rom_m[g][rp[L-1]];
    assign ram_dout_m[g] = ram[mp[L-1]] ^ corrupt_m[g][mp[L-1]];
  end

  // Runs one job on instance w and scores every cycle against the timing rules:
  // busy window, write window with address/data, read address sequence, done pulse.
  task automatic run_job(input int w, input int abort_cyc, input int budget,
                         output int n_wr, output int wr_bad, output int busy_bad,
                         output int rom_bad, output int done_cyc, output int n_done,
                         output logic [10:0] cnt_c1);
    int d, l, cl, bend, off, ea;
    logic eb, ew;
    d = dep_of(w); l = lat_of(w); cl = d + l;
    bend = (1 + ver_of(w)) * cl;
    n_wr = 0; wr_bad = 0; busy_bad = 0; rom_bad = 0; done_cyc = -1; n_done = 0; cnt_c1 = '1;
    @(posedge clk); #1 start_m[w] = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1 start_m[w] = 1'b0;
      abort_m[w] = (c == abort_cyc);
      @(negedge clk);
      eb = (c <= bend) && !(abort_cyc > 0 && c > abort_cyc);
      ew = (c >= 1 + l) && (c <= cl) && !(abort_cyc > 0 && c >= abort_cyc);
      if (busy_m[w] !== eb) busy_bad++;
      if (ram_we_m[w] === 1'b1) n_wr++;
      if (ew) begin
        if (ram_we_m[w] !== 1'b1 || ram_addr_m[w] !== 10'(c - 1 - l) ||
            ram_din_m[w] !== rom_m[w][c - 1 - l]) wr_bad++;
      end else if (ram_we_m[w] !== 1'b0) wr_bad++;
      if (eb) begin
        off = (c <= cl) ? c - 1 : c - cl - 1;
        ea  = (off < d) ? off : d - 1;
        if (rom_addr_m[w] !== 10'(ea)) rom_bad++;
        if (c > cl && ram_addr_m[w] !== 10'(ea)) rom_bad++;
      end
      if (done_m[w] === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == 1) cnt_c1 = err_cnt_m[w];
    end
    abort_m[w] = 1'b0;
  endtask

  task automatic clear_corrupt(input int w);
    for (int i = 0; i < 1024; i++) corrupt_m[w][i] = 8'h00;
  endtask

  task automatic test_reset;
    logic [52:0] v;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      v = {busy_m[w], done_m[w], ram_we_m[w], err_flag_m[w], rom_addr_m[w], ram_addr_m[w],
           ram_din_m[w], err_cnt_m[w], first_err_m[w]};
      checks++;
      if (v !== '0) begin errors++; $display("FAIL reset_outputs inst%0d: got %h want 0", w, v); end
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_copy_verify;
    int n_wr, wr_bad, busy_bad, rom_bad, dc, nd;
    logic [10:0] c1;
    for (int i = 0; i < 1024; i++) rom_m[0][i] = 8'(i);
    clear_corrupt(0);
    run_job(0, 0, job_len(0) + 4, n_wr, wr_bad, busy_bad, rom_bad, dc, nd, c1);
    checks++; if (wr_bad !== 0) begin errors++; $display("FAIL copy_writes: bad=%0d want 0", wr_bad); end
    checks++; if (n_wr !== 1024) begin errors++; $display("FAIL copy_write_count: got %0d want 1024", n_wr); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL copy_busy: bad=%0d want 0", busy_bad); end
    checks++; if (rom_bad !== 0) begin errors++; $display("FAIL copy_rd_addr: bad=%0d want 0", rom_bad); end
    checks++; if (dc !== 2051) begin errors++; $display("FAIL copy_done_cycle: got %0d want 2051", dc); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL copy_done_count: got %0d want 1", nd); end
    checks++; if (err_cnt_m[0] !== 11'd0 || err_flag_m[0] !== 1'b0) begin
      errors++; $display("FAIL copy_no_err: cnt=%0d flag=%0d want 0 0", err_cnt_m[0], err_flag_m[0]); end
  endtask

  task automatic test_verify_errors;
    int n_wr, wr_bad, busy_bad, rom_bad, dc, nd, k, a, ecnt, efirst;
    logic [10:0] c1;
    for (int i = 0; i < 1024; i++) rom_m[0][i] = 8'($urandom);
    clear_corrupt(0);
    corrupt_m[0][5]   = 8'($urandom_range(1, 255));
    corrupt_m[0][700] = 8'($urandom_range(1, 255));
    run_job(0, 0, job_len(0) + 4, n_wr, wr_bad, busy_bad, rom_bad, dc, nd, c1);
    checks++; if (err_cnt_m[0] !== 11'd2) begin errors++; $display("FAIL verify_err_cnt: got %0d want 2", err_cnt_m[0]); end
    checks++; if (first_err_m[0] !== 10'd5) begin errors++; $display("FAIL verify_first_err: got %0d want 5", first_err_m[0]); end
    checks++; if (err_flag_m[0] !== 1'b1) begin errors++; $display("FAIL verify_err_flag: got %0d want 1", err_flag_m[0]); end
    checks++; if (dc !== 2051) begin errors++; $display("FAIL verify_done_cycle: got %0d want 2051", dc); end
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++; if (err_cnt_m[0] !== 11'd2 || first_err_m[0] !== 10'd5 || err_flag_m[0] !== 1'b1) begin
      errors++; $display("FAIL verify_hold: cnt=%0d first=%0d flag=%0d want 2 5 1",
                         err_cnt_m[0], first_err_m[0], err_flag_m[0]); end
    // Random damage pattern; expected results come straight from the mask contents.
    clear_corrupt(0);
    k = $urandom_range(0, 6);
    for (int j = 0; j < k; j++) begin
      a = $urandom_range(0, 1023);
      corrupt_m[0][a] = 8'($urandom_range(1, 255));
    end
    ecnt = 0; efirst = 0;
    for (int i = 0; i < 1024; i++) if (corrupt_m[0][i] != 8'h00) begin
      if (ecnt == 0) efirst = i;
      ecnt++;
    end
    run_job(0, 0, job_len(0) + 4, n_wr, wr_bad, busy_bad, rom_bad, dc, nd, c1);
    checks++; if (c1 !== 11'd0) begin errors++; $display("FAIL start_clears_err: got %0d want 0", c1); end
    checks++; if (err_cnt_m[0] !== 11'(ecnt)) begin errors++; $display("FAIL rand_err_cnt: got %0d want %0d", err_cnt_m[0], ecnt); end
    checks++; if (first_err_m[0] !== 10'(efirst)) begin errors++; $display("FAIL rand_first_err: got %0d want %0d", first_err_m[0], efirst); end
    checks++; if (wr_bad !== 0 || rom_bad !== 0) begin errors++; $display("FAIL rand_copy: wr_bad=%0d rd_bad=%0d want 0 0", wr_bad, rom_bad); end
  endtask

  task automatic test_no_verify_lat3;
    int n_wr, wr_bad, busy_bad, rom_bad, dc, nd;
    logic [10:0] c1;
    for (int i = 0; i < 1024; i++) rom_m[1][i] = 8'($urandom);
    run_job(1, 0, 26, n_wr, wr_bad, busy_bad, rom_bad, dc, nd, c1);
    checks++; if (wr_bad !== 0) begin errors++; $display("FAIL lat3_writes: bad=%0d want 0", wr_bad); end
    checks++; if (n_wr !== 16) begin errors++; $display("FAIL lat3_write_count: got %0d want 16", n_wr); end
    checks++; if (dc !== 20) begin errors++; $display("FAIL lat3_done_cycle: got %0d want 20", dc); end
    checks++; if (busy_bad !== 0 || rom_bad !== 0) begin errors++; $display("FAIL lat3_busy_rd: busy_bad=%0d rd_bad=%0d want 0 0", busy_bad, rom_bad); end
  endtask

  task automatic test_abort;
    int n_wr, wr_bad, busy_bad, rom_bad, dc, nd;
    logic [10:0] c1;
    for (int i = 0; i < 1024; i++) rom_m[0][i] = 8'($urandom);
    clear_corrupt(0);
    run_job(0, 100, 130, n_wr, wr_bad, busy_bad, rom_bad, dc, nd, c1);
    checks++; if (wr_bad !== 0) begin errors++; $display("FAIL abort_writes: bad=%0d want 0", wr_bad); end
    checks++; if (n_wr !== 98) begin errors++; $display("FAIL abort_write_count: got %0d want 98", n_wr); end
    checks++; if (nd !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", nd); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL abort_busy: bad=%0d want 0", busy_bad); end
    run_job(0, 0, job_len(0) + 4, n_wr, wr_bad, busy_bad, rom_bad, dc, nd, c1);
    checks++; if (n_wr !== 1024 || wr_bad !== 0) begin errors++; $display("FAIL abort_restart: writes=%0d bad=%0d want 1024 0", n_wr, wr_bad); end
    checks++; if (err_cnt_m[0] !== 11'd0 || dc !== 2051) begin errors++; $display("FAIL abort_restart_done: cnt=%0d done=%0d want 0 2051", err_cnt_m[0], dc); end
    // start and abort together in IDLE: the job must still begin.
    @(posedge clk); #1 start_m[2] = 1'b1; abort_m[2] = 1'b1;
    @(posedge clk); #1 start_m[2] = 1'b0; abort_m[2] = 1'b0;
    @(negedge clk);
    checks++; if (busy_m[2] !== 1'b1) begin errors++; $display("FAIL start_beats_abort: busy=%0d want 1", busy_m[2]); end
    repeat (12) @(posedge clk);
  endtask

  task automatic test_depth1;
    int n_wr, wr_bad, busy_bad, rom_bad, dc, nd;
    logic [10:0] c1;
    rom_m[2][0] = 8'($urandom);
    clear_corrupt(2);
    corrupt_m[2][0] = 8'($urandom_range(1, 255));
    run_job(2, 0, 12, n_wr, wr_bad, busy_bad, rom_bad, dc, nd, c1);
    checks++; if (n_wr !== 1 || wr_bad !== 0) begin errors++; $display("FAIL d1_write: writes=%0d bad=%0d want 1 0", n_wr, wr_bad); end
    checks++; if (dc !== 7) begin errors++; $display("FAIL d1_done_cycle: got %0d want 7", dc); end
    checks++; if (err_cnt_m[2] !== 11'd1 || first_err_m[2] !== 10'd0 || err_flag_m[2] !== 1'b1) begin
      errors++; $display("FAIL d1_compare: cnt=%0d first=%0d flag=%0d want 1 0 1",
                         err_cnt_m[2], first_err_m[2], err_flag_m[2]); end
    checks++; if (busy_bad !== 0 || rom_bad !== 0) begin errors++; $display("FAIL d1_busy_rd: busy_bad=%0d rd_bad=%0d want 0 0", busy_bad, rom_bad); end
    clear_corrupt(2);
  endtask

  task automatic test_back_to_back;
    int t_len, next_free, acc, bad;
    int exp_q[$];
    int obs_q[$];
    logic s;
    t_len = job_len(2);
    next_free = 0; acc = 0; bad = 0;
    for (int t = 0; t < 90; t++) begin
      @(posedge clk); #1;
      s = (t < 80) ? 1'($urandom_range(0, 1)) : 1'b0;
      start_m[2] = s;
      if (s && t >= next_free) begin
        exp_q.push_back(t + t_len);
        next_free = t + t_len + 1;
        acc++;
      end
      @(negedge clk);
      if (done_m[2] === 1'b1) obs_q.push_back(t);
    end
    checks++; if (obs_q.size() !== acc) begin errors++; $display("FAIL b2b_done_count: got %0d want %0d", obs_q.size(), acc); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] != exp_q[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_done_timing: bad=%0d want 0", bad); end
  endtask

  task automatic test_reset_mid_verify;
    logic [52:0] v;
    int n_we, n_busy;
    @(posedge clk); #1 start_m[0] = 1'b1;
    @(posedge clk); #1 start_m[0] = 1'b0;
    repeat (1499) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    v = {busy_m[0], done_m[0], ram_we_m[0], err_flag_m[0], rom_addr_m[0], ram_addr_m[0],
         ram_din_m[0], err_cnt_m[0], first_err_m[0]};
    checks++; if (v !== '0) begin errors++; $display("FAIL midrst_outputs: got %h want 0", v); end
    n_we = 0; n_busy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ram_we_m[0] !== 1'b0) n_we++;
      if (busy_m[0] !== 1'b0 || done_m[0] !== 1'b0) n_busy++;
    end
    checks++; if (n_we !== 0 || n_busy !== 0) begin errors++; $display("FAIL midrst_quiet: we=%0d busy=%0d want 0 0", n_we, n_busy); end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int w = 0; w < 3; w++) begin
      start_m[w] = 1'b0;
      abort_m[w] = 1'b0;
      for (int i = 0; i < 1024; i++) begin
        rom_m[w][i] = 8'h00;
        corrupt_m[w][i] = 8'h00;
      end
    end
    test_reset();
    test_copy_verify();
    test_verify_errors();
    test_no_verify_lat3();
    test_abort();
    test_depth1();
    test_back_to_back();
    test_reset_mid_verify();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
